// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : Buffers bytes completed by the UART receiver in a power-of-two
//             FIFO and launches them one at a time into the UART transmitter,
//             pacing launches on the transmitter busy flag. Bytes arriving
//             while the FIFO is full are dropped and flagged (sticky).
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
   parameter int DEPTH        = 16,
   parameter int WIDTH        = 8,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx_strobe,
   input  logic [WIDTH-1:0]         rx_data,
   input  logic                     tx_busy,
   output logic                     tx_start,
   output logic [WIDTH-1:0]         tx_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   // Timeout counter must be able to hold BUSY_TIMEOUT itself.
   localparam int TW = (BUSY_TIMEOUT < 1) ? 1 : $clog2(BUSY_TIMEOUT + 1);
   localparam logic [AW:0] C_FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [TW-1:0] C_TMO     = TW'(BUSY_TIMEOUT);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             strobe_q;
   logic             overflow_q;
   logic             tx_start_q;
   logic             tx_start_d;
   logic [WIDTH-1:0] tx_data_q;
   state_t           state_q;
   state_t           state_d;
   logic [TW-1:0]    tmo_q;
   logic [TW-1:0]    tmo_d;

   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_push_ok;
   logic w_pop;

   // Occupancy flags decode straight from the registered count.
   assign w_empty = (count_q == '0);
   assign w_full  = (count_q == C_FULL_CNT);

   // Rising edge of the receiver flag; a held level yields a single push.
   assign w_push    = rx_strobe & ~strobe_q;
   // A push while full is dropped even if a pop frees a slot on the same edge.
   assign w_push_ok = w_push & ~w_full;
   // Pop only from IDLE with data available and the transmitter free.
   assign w_pop     = (state_q == IDLE) & ~w_empty & ~tx_busy;

   // FIFO storage write; contents need no reset since count gates reads.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         mem_q[wr_ptr_q] <= rx_data;
      end
   end

   // Pointers, occupancy, strobe history and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         strobe_q   <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         strobe_q <= rx_strobe;
         if (w_push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (w_push && w_full) begin
            overflow_q <= 1'b1;
         end
         case ({w_push_ok, w_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Transmit sequencer state, launch pulse and launched byte registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         tmo_q      <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         tx_start_q <= tx_start_d;
         if (w_pop) begin
            tx_data_q <= mem_q[rd_ptr_q];
         end
      end
   end

   // Next-state logic: launch, wait for busy to rise (bounded), wait for done.
   always_comb begin
      state_d    = state_q;
      tmo_d      = tmo_q;
      tx_start_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (w_pop) begin
               state_d    = WAIT_BUSY;
               tmo_d      = '0;
               tx_start_d = 1'b1;
            end
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if (tmo_q >= C_TMO) begin
               // Transmitter never acknowledged; treat the byte as sent.
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
   assign count    = count_q;
   assign empty    = w_empty;
   assign full     = w_full;
   assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Byte buffer and transmit sequencer between the UART receiver and the UART transmitter in the loopback and echo designs. It captures each byte the receiver completes into a power-of-two FIFO and launches stored bytes into the transmitter one at a time, each with a single-cycle start pulse, pacing them on the transmitter's busy flag. Bursts arriving faster than the transmitter drains are absorbed, and lost bytes are flagged instead of being silently overwritten.

## Interface
- DEPTH, 16, FIFO entries; power of two, minimum 2
- WIDTH, 8, data bits per entry
- BUSY_TIMEOUT, 4, cycles spent waiting for tx_busy to rise before abandoning the wait
- clk  input  1  system clock (27 MHz on the board)
- rst  input  1  reset; synchronous, active-high
- rx_strobe  input  1  receiver completion flag; may be a pulse or a held level
- rx_data  input  WIDTH  received byte; valid while rx_strobe is high
- tx_busy  input  1  transmitter busy flag
- tx_start  output  1  one-cycle launch pulse to the transmitter
- tx_data  output  WIDTH  byte presented to the transmitter
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- empty  output  1  high when count == 0
- full  output  1  high when count == DEPTH
- overflow  output  1  sticky; a byte was dropped

## Operation
- Capture:
  - rx_strobe is registered into strobe_q.
  - A byte is pushed when rx_strobe && !strobe_q, so a held-high strobe produces exactly one push.
- Push:
  - Writes rx_data to mem[wr_ptr] and increments wr_ptr.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- Push while full:
  - The byte is dropped and overflow is set.
  - This applies even if a pop happens on the same edge.
  - overflow clears only on rst.
- Transmit FSM has three states: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - When !empty && !tx_busy, on the edge: tx_data <= mem[rd_ptr], rd_ptr++ (pop), tx_start <= 1, state goes to WAIT_BUSY, timeout counter clears.
  - Otherwise the FSM stays in IDLE.
- WAIT_BUSY:
  - tx_start <= 0 on the first edge.
  - If tx_busy, go to WAIT_DONE.
  - Otherwise increment the counter; after BUSY_TIMEOUT cycles without tx_busy, return to IDLE (the byte counts as sent).
- WAIT_DONE: when !tx_busy, go to IDLE.
- Push and pop on the same edge (not full): count is unchanged and both pointers advance.
- count is computed as a registered counter: +1 on push only, -1 on pop only.
- empty and full are decoded combinationally from count.
- tx_data holds the last launched byte between launches.

## Timing
- Reset values:
  - tx_start=0, tx_data=0, count=0, empty=1, full=0, overflow=0
  - FSM=IDLE, pointers=0
  - strobe_q=1, so a strobe already high when rst releases is not captured
- rst mid-operation:
  - FIFO contents are discarded and the FSM returns to IDLE on the next edge.
  - A tx_start pulse in flight is cut to one cycle or less.
- Latency, empty FIFO with idle transmitter:
  - Edge E0 samples the rx_strobe rise and pushes.
  - Edge E1 pops and raises tx_start.
  - tx_start is high between E1 and E2.
  - tx_data is valid from E1 and stable through the transmission.
- tx_start is never high for two consecutive cycles.
- Minimum spacing between launches is 3 cycles (launch, WAIT_BUSY, IDLE) even if tx_busy never rises. Normally spacing equals the transmitter frame time plus 2 cycles.
- The FIFO never pops while empty.
- tx_busy high in IDLE blocks launch. This covers the case where the transmitter is driven by another source.

## Test plan
- Single byte: rx_strobe pulses with rx_data=0x21 and tx_busy is modelled as 10 cycles starting 1 cycle after tx_start. Required: tx_start high exactly 1 cycle, at E0+1, with tx_data=0x21; count goes 0→1→0; empty returns to 1.
- Held strobe: rx_strobe held high for 50 cycles with rx_data=0x41. Required: exactly one push (count peaks at 1) and exactly one tx_start.
- Burst and order: 20 bytes 0x00..0x13, one every 4 cycles, against a 100-cycle busy model with DEPTH=16. Required: the first bytes are sent in order; overflow sets once count hits 16 with further strobes; the bytes that are transmitted appear in strictly increasing order with no duplicates.
- Simultaneous push/pop:
  - Setup: FIFO holds 3 bytes; a strobe rise lands on the same edge as an IDLE launch.
  - Required: count stays 3 and the new byte is transmitted last.
- Full plus pop:
  - Setup: FIFO full; a strobe rise coincides with a pop.
  - Required: the byte is dropped, overflow=1, count=DEPTH-1.
- Busy timeout and reset:
  - Stimulus: tx_busy tied 0 with 3 bytes queued.
  - Required: tx_start pulses are exactly 3 cycles apart with BUSY_TIMEOUT=1 (or BUSY_TIMEOUT+2 in general).
  - Then assert rst for 1 cycle mid-queue. Required: all outputs return to their reset values on the next edge and no further tx_start appears.
